// File: rtl/sha2_msg_sched_if.sv
// SHA-2 message-schedule handshake bundle: block load port plus schedule word stream.
// Latency: none, this is wiring only.
// Backpressure: o_ld_ready throttles loading and i_ready stalls the word stream.
interface sha2_msg_sched_if #(
    parameter int WORD_W = 32
);
    logic              i_start;
    logic              i_ld_valid;
    logic [WORD_W-1:0] i_ld_data;
    logic              o_ld_ready;
    logic [WORD_W-1:0] o_w;
    logic [7:0]        o_t;
    logic              o_valid;
    logic              i_ready;
    logic              o_busy;
    logic              o_done;

    modport master (
        output i_start, i_ld_valid, i_ld_data, i_ready,
        input  o_ld_ready, o_w, o_t, o_valid, o_busy, o_done
    );

    modport slave (
        input  i_start, i_ld_valid, i_ld_data, i_ready,
        output o_ld_ready, o_w, o_t, o_valid, o_busy, o_done
    );
endinterface

// File: rtl/sha2_msg_sched.sv
// SHA-256/512 message schedule: loads 16 words, then streams W[0..ROUNDS-1].
// Latency: start takes 1 cycle, load takes 16 cycles minimum, then one word per cycle.
// Backpressure: i_ready low freezes the window, o_w and o_t; loading follows i_ld_valid.
module sha2_msg_sched #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic           i_clk,
    input  logic           i_rst,
    sha2_msg_sched_if.slave bus
);
    if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
        $error("sha2_msg_sched: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 16 || ROUNDS > 255) begin : g_bad_rounds
        $error("sha2_msg_sched: ROUNDS must be in 16..255");
    end

    // Rotate/shift amounts of the two sigma functions for the selected family.
    localparam int S0_R1 = (WORD_W == 64) ? 1  : 7;
    localparam int S0_R2 = (WORD_W == 64) ? 8  : 18;
    localparam int S0_SH = (WORD_W == 64) ? 7  : 3;
    localparam int S1_R1 = (WORD_W == 64) ? 19 : 17;
    localparam int S1_R2 = (WORD_W == 64) ? 61 : 19;
    localparam int S1_SH = (WORD_W == 64) ? 6  : 10;
    localparam logic [7:0] LAST_T = 8'(ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WORD_W-1:0] r_win [16];
    logic [3:0]        r_cnt;
    logic [7:0]        r_t;
    logic              r_done;
    logic              w_ld_xfer;
    logic              w_out_xfer;
    logic              w_last;
    logic [WORD_W-1:0] w_new;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
    endfunction

    // W[t+16] from the window holding W[t..t+15]; carries out of the top bit drop.
    assign w_new = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

    always_comb begin
        w_state_nxt = r_state;
        w_ld_xfer   = 1'b0;
        w_out_xfer  = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_ld_xfer = bus.i_ld_valid;
                if (w_ld_xfer && (r_cnt == 4'd15)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_out_xfer = bus.i_ready;
                w_last     = w_out_xfer && (r_t == LAST_T);
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_t     <= 8'd0;
            r_done  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last;
            if ((r_state == ST_IDLE) && bus.i_start) begin
                r_cnt <= 4'd0;
            end
            if (w_ld_xfer) begin
                r_win[r_cnt] <= bus.i_ld_data;
                r_cnt        <= r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    r_t <= 8'd0;
                end
            end
            // The window shifts on every transfer, so W[0..15] leave exactly as loaded.
            if (w_out_xfer) begin
                for (int i = 0; i < 15; i++) begin
                    r_win[i] <= r_win[i+1];
                end
                r_win[15] <= w_new;
                r_t       <= r_t + 8'd1;
            end
        end
    end

    assign bus.o_ld_ready = (r_state == ST_LOAD);
    assign bus.o_valid    = (r_state == ST_RUN);
    assign bus.o_busy     = (r_state == ST_LOAD) || (r_state == ST_RUN);
    assign bus.o_done     = r_done;
    assign bus.o_w        = r_win[0];
    assign bus.o_t        = r_t;
endmodule

// File: tb/tb_sha2_msg_sched.sv
// Bench for sha2_msg_sched with one SHA-256 and one SHA-512 instance against a scoreboard.
// Latency: expected words are queued at load time and popped on each output transfer.
// Backpressure: i_ready is randomised per cycle; stalled outputs must hold.
module tb_sha2_msg_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha2_msg_sched_if #(.WORD_W(32)) ifa ();
    sha2_msg_sched_if #(.WORD_W(64)) ifb ();

    sha2_msg_sched #(.WORD_W(32), .ROUNDS(64)) u_dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa.slave));
    sha2_msg_sched #(.WORD_W(64), .ROUNDS(80)) u_dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb.slave));

    typedef struct packed {
        logic [63:0] w;
        logic [7:0]  t;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt [2];

    logic        d_start    [2];
    logic        d_ld_valid [2];
    logic [63:0] d_ld_data  [2];
    logic        d_ready    [2];
    logic        v_ldr  [2];
    logic        v_val  [2];
    logic        v_busy [2];
    logic        v_done [2];
    logic [63:0] v_w    [2];
    logic [7:0]  v_t    [2];

    assign ifa.i_start    = d_start[0];
    assign ifa.i_ld_valid = d_ld_valid[0];
    assign ifa.i_ld_data  = d_ld_data[0][31:0];
    assign ifa.i_ready    = d_ready[0];
    assign ifb.i_start    = d_start[1];
    assign ifb.i_ld_valid = d_ld_valid[1];
    assign ifb.i_ld_data  = d_ld_data[1];
    assign ifb.i_ready    = d_ready[1];

    assign v_ldr[0]  = ifa.o_ld_ready;
    assign v_val[0]  = ifa.o_valid;
    assign v_busy[0] = ifa.o_busy;
    assign v_done[0] = ifa.o_done;
    assign v_w[0]    = {32'h0, ifa.o_w};
    assign v_t[0]    = ifa.o_t;
    assign v_ldr[1]  = ifb.o_ld_ready;
    assign v_val[1]  = ifb.o_valid;
    assign v_busy[1] = ifb.o_busy;
    assign v_done[1] = ifb.o_done;
    assign v_w[1]    = ifb.o_w;
    assign v_t[1]    = ifb.o_t;

    initial begin
        done_cnt[0] = 0;
        done_cnt[1] = 0;
    end

    always @(negedge clk) begin
        if (ifa.o_done) done_cnt[0] = done_cnt[0] + 1;
        if (ifb.o_done) done_cnt[1] = done_cnt[1] + 1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rr32(input logic [63:0] x, input int n);
        logic [31:0] y;
        y = x[31:0];
        return {32'h0, (y >> n) | (y << (32 - n))};
    endfunction

    function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] ms0(input int sel, input logic [63:0] x);
        if (sel == 1) return rr64(x, 1) ^ rr64(x, 8) ^ (x >> 7);
        return rr32(x, 7) ^ rr32(x, 18) ^ ({32'h0, x[31:0]} >> 3);
    endfunction

    function automatic logic [63:0] ms1(input int sel, input logic [63:0] x);
        if (sel == 1) return rr64(x, 19) ^ rr64(x, 61) ^ (x >> 6);
        return rr32(x, 17) ^ rr32(x, 19) ^ ({32'h0, x[31:0]} >> 10);
    endfunction

    // Textbook recurrence W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
    task automatic push_model(input int sel, input logic [63:0] m [16]);
        logic [63:0] wm [256];
        logic [63:0] mask;
        int          n;
        exp_t        e;
        n    = (sel == 1) ? 80 : 64;
        mask = (sel == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        for (int t = 0; t < 16; t++) wm[t] = m[t] & mask;
        for (int t = 16; t < n; t++)
            wm[t] = (ms1(sel, wm[t-2]) + wm[t-7] + ms0(sel, wm[t-15]) + wm[t-16]) & mask;
        for (int t = 0; t < n; t++) begin
            e.w = wm[t];
            e.t = 8'(t);
            if (sel == 1) sb1.push_back(e);
            else          sb0.push_back(e);
        end
    endtask

    task automatic chk_idle_outputs(input int sel, input string tag);
        chk({tag, "_ld_ready"}, 64'(v_ldr[sel]), 64'd0);
        chk({tag, "_valid"},    64'(v_val[sel]), 64'd0);
        chk({tag, "_busy"},     64'(v_busy[sel]), 64'd0);
        chk({tag, "_done"},     64'(v_done[sel]), 64'd0);
        chk({tag, "_w"},        v_w[sel], 64'd0);
        chk({tag, "_t"},        64'(v_t[sel]), 64'd0);
    endtask

    // Entered and left at a falling edge; ends with the block in RUN.
    task automatic load_block(input int sel, input logic [63:0] m [16], input bit gaps, input bit start_in_load);
        int idx = 0;
        int cyc = 0;
        bit v;
        push_model(sel, m);
        @(negedge clk);
        d_start[sel] = 1'b1;
        @(negedge clk);
        d_start[sel] = 1'b0;
        chk("ld_ready_rise", 64'(v_ldr[sel]), 64'd1);
        while (idx < 16 && cyc < 200) begin
            chk("no_valid_in_load", 64'(v_val[sel]), 64'd0);
            v = gaps ? (cyc[0] == 1'b0) : 1'b1;
            d_ld_valid[sel] = v;
            d_ld_data[sel]  = v ? m[idx] : {$urandom, $urandom};
            d_start[sel]    = start_in_load && (idx == 8);
            if (v && v_ldr[sel]) idx++;
            cyc++;
            @(negedge clk);
        end
        d_ld_valid[sel] = 1'b0;
        d_start[sel]    = 1'b0;
        chk("load_words", 64'(idx), 64'd16);
        chk("run_valid", 64'(v_val[sel]), 64'd1);
        chk("ld_ready_fall", 64'(v_ldr[sel]), 64'd0);
        chk("run_t0", 64'(v_t[sel]), 64'd0);
    endtask

    task automatic consume(input int sel, input int n_xfer, input int rdy_pct, input bit expect_done,
                           input bit use_gold, input logic [63:0] g16, input logic [63:0] g17);
        int          got = 0;
        int          cyc = 0;
        int          d0;
        bit          stalled = 1'b0;
        logic [63:0] hw = '0;
        logic [7:0]  ht = '0;
        exp_t        e;
        bit          empty;
        d0 = done_cnt[sel];
        while (got < n_xfer && cyc < 4000) begin
            if (stalled) begin
                chk("stall_w", v_w[sel], hw);
                chk("stall_t", 64'(v_t[sel]), 64'(ht));
            end
            chk("valid_held", 64'(v_val[sel]), 64'd1);
            d_ready[sel] = ($urandom_range(99) < rdy_pct);
            if (v_val[sel] && d_ready[sel]) begin
                empty = (sel == 1) ? (sb1.size() == 0) : (sb0.size() == 0);
                if (empty) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = (sel == 1) ? sb1.pop_front() : sb0.pop_front();
                    chk("w", v_w[sel], e.w);
                    chk("t", 64'(v_t[sel]), 64'(e.t));
                end
                if (use_gold && v_t[sel] == 8'd16) chk("w16_gold", v_w[sel], g16);
                if (use_gold && v_t[sel] == 8'd17) chk("w17_gold", v_w[sel], g17);
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                hw = v_w[sel];
                ht = v_t[sel];
            end
            cyc++;
            @(negedge clk);
        end
        d_ready[sel] = 1'b0;
        chk("xfer_count", 64'(got), 64'(n_xfer));
        if (expect_done) begin
            chk("done_pulse", 64'(v_done[sel]), 64'd1);
            chk("valid_drop", 64'(v_val[sel]), 64'd0);
            chk("busy_drop", 64'(v_busy[sel]), 64'd0);
            @(negedge clk);
            chk("done_once", 64'(v_done[sel]), 64'd0);
            chk("done_count", 64'(done_cnt[sel] - d0), 64'd1);
            chk("sb_empty", 64'((sel == 1) ? sb1.size() : sb0.size()), 64'd0);
        end
    endtask

    logic [63:0] blk [16];
    int          d_abort;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            d_start[s]    = 1'b0;
            d_ld_valid[s] = 1'b0;
            d_ld_data[s]  = '0;
            d_ready[s]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_idle_outputs(0, "rst_a");
        chk_idle_outputs(1, "rst_b");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            d_ld_valid[0] = c[0];
            d_ld_valid[1] = c[0];
            d_ld_data[0]  = 64'hDEAD_BEEF;
            d_ld_data[1]  = 64'hDEAD_BEEF_0BAD_F00D;
            @(negedge clk);
            chk("idle_ld_ready_a", 64'(v_ldr[0]), 64'd0);
            chk("idle_busy_a", 64'(v_busy[0]), 64'd0);
            chk("idle_busy_b", 64'(v_busy[1]), 64'd0);
            chk("idle_valid_b", 64'(v_val[1]), 64'd0);
        end
        d_ld_valid[0] = 1'b0;
        d_ld_valid[1] = 1'b0;

        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0]  = 64'h6162_6380;
        blk[15] = 64'h18;
        load_block(0, blk, 1'b0, 1'b0);
        consume(0, 64, 100, 1'b1, 1'b1, 64'h6162_6380, 64'h000F_0000);

        blk[0] = 64'h6162_6380_0000_0000;
        load_block(1, blk, 1'b0, 1'b0);
        consume(1, 80, 100, 1'b1, 1'b1, 64'h6162_6380_0000_0000, 64'h0003_0000_0000_00C0);

        blk[0] = 64'h6162_6380;
        load_block(0, blk, 1'b0, 1'b0);
        consume(0, 64, 50, 1'b1, 1'b0, 64'd0, 64'd0);

        for (int i = 0; i < 16; i++) blk[i] = {32'h0, $urandom};
        load_block(0, blk, 1'b0, 1'b0);
        d_start[0] = 1'b1;
        d_abort = done_cnt[0];
        consume(0, 30, 70, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("abort_t30", 64'(v_t[0]), 64'd30);
        d_start[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_idle_outputs(0, "abort_rst");
        @(negedge clk);
        rst = 1'b0;
        sb0.delete();
        repeat (3) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt[0] - d_abort), 64'd0);
        chk("abort_idle_busy", 64'(v_busy[0]), 64'd0);

        for (int i = 0; i < 16; i++) blk[i] = {32'h0, $urandom};
        load_block(0, blk, 1'b1, 1'b1);
        consume(0, 64, 100, 1'b1, 1'b0, 64'd0, 64'd0);

        for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom};
        load_block(1, blk, 1'b1, 1'b0);
        consume(1, 80, 60, 1'b1, 1'b0, 64'd0, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
